traffic_phase_sched: RTL and testbench
======================================

Name: traffic_phase_sched

Overview:
- Phase sequencer for the 8:1 signal-pattern mux.
- Drives the mux select lines S1/S2/S3 and steps through eight traffic phases.
- Each phase dwells for the 5-bit duration value that the mux returns for the currently selected input.
- Skips phases with no demand (MASK), and supports emergency pre-emption to a fixed hold phase.

Parameters:
PRESCALE, 4, clock cycles per duration unit (>=1)
EMG_PHASE, 0, phase index forced while EMG is asserted (0..7)
MIN_TIME, 1, minimum dwell in units, substituted when the mux returns 0 (1..31)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
EN  input  1  run enable; 0 freezes sequencing
MASK  input  8  phase enable; bit n=1 means phase n is visited
EMG  input  1  emergency pre-empt request, level
Y_IN  input  5  duration of selected phase, from mux Y (combinational return)
S1  output  1  mux select, phase[0]
S2  output  1  mux select, phase[1]
S3  output  1  mux select, phase[2]
PHASE  output  3  current phase index {S3,S2,S1}
PHASE_CHG  output  1  one-cycle pulse on the cycle after the phase register changes
EMG_ACT  output  1  high while in HOLD state

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high. All state is registered and all outputs are registered.
- Reset values: state=IDLE, phase=0 (S1=S2=S3=0), timer=0, presc=0, PHASE_CHG=0, EMG_ACT=0.
- rst dominates EMG and EN. Mid-operation reset returns to IDLE on the next edge.
- States: IDLE, LOAD, RUN, HOLD.
- IDLE: if EMG -> HOLD; else if EN -> LOAD; else stay.
- LOAD (1 cycle):
  - timer <= (Y_IN==0) ? MIN_TIME : Y_IN; presc <= 0; -> RUN.
  - If EN=0, stay in LOAD; no load occurs.
- RUN:
  - If EN=1: presc increments; on presc==PRESCALE-1, presc <= 0 and timer decrements.
  - Expiry is presc==PRESCALE-1 with timer==1. On expiry: phase <= next enabled phase; -> LOAD.
  - Next enabled phase: the first set MASK bit searching upward from phase+1, wrapping 7->0. MASK is sampled on the expiry cycle.
  - If MASK==0, or the only set bit is the current phase, phase is unchanged and the phase reloads.
  - If EN=0: presc and timer hold, state holds.
- Dwell: from entering LOAD to the next LOAD = 1 + T*PRESCALE cycles, where T is the loaded timer value.
- PHASE_CHG: 1 only on the cycle after the phase register actually changes value. A reload of the same phase gives no pulse.
- EMG handling:
  - EMG=1 in IDLE/LOAD/RUN (EN ignored): next edge state=HOLD, phase <= EMG_PHASE, EMG_ACT=1, timer/presc cleared.
  - EMG beats expiry in the same cycle.
- HOLD: stays while EMG=1; phase stays at EMG_PHASE.
- HOLD exit: on EMG=0, phase <= next enabled phase after EMG_PHASE (EMG_PHASE itself if MASK==0); EMG_ACT <= 0; -> LOAD if EN=1, else IDLE.
- Widths: timer 5 bits, presc is ceil(log2(PRESCALE)) bits (min 1), phase 3 bits.
- Arithmetic and timing: no arithmetic overflow is possible; Y_IN=31 gives a dwell of 1+31*PRESCALE cycles. Y_IN must be stable for the LOAD cycle; it is valid because S1..S3 are registered one cycle earlier.

Test Plan:
- Reset/default: rst high 3 cycles with EN=1, EMG=1 -> S=000, PHASE_CHG=0, EMG_ACT=0, state IDLE.
- Full rotation: PRESCALE=4, MASK=8'hFF, durations 1..8 on phases 0..7, EN=1 -> PHASE visits 0,1,...,7,0. Phase n dwells 1+4*(n+1) cycles; PHASE_CHG pulses 8 times per rotation.
- Skip/wrap: MASK=8'b1000_0101 starting at phase 0 -> sequence 0,2,7,0. MASK=0 -> phase 0 reloads forever, no PHASE_CHG.
- Zero duration and freeze: Y_IN=0 on phase 3 -> dwell 1+MIN_TIME*4=5 cycles. EN dropped for 10 cycles mid-RUN -> the dwell extends by exactly 10 cycles.
- Emergency: EMG asserted in phase 5 on its expiry cycle -> next edge PHASE=EMG_PHASE(0), EMG_ACT=1, PHASE_CHG pulse. EMG released with MASK=8'b0001_0001 -> PHASE=4, LOAD, EMG_ACT=0.
- Emergency with EN=0: EMG pulse while IDLE -> HOLD. On release -> IDLE at next enabled phase after EMG_PHASE.

Source files
------------

// File: rtl/traffic_phase_sched.sv
// Phase sequencer for an 8:1 signal-pattern mux: drives S1..S3, dwells each phase for
// the duration the mux returns, skips masked phases and supports emergency pre-emption.
module traffic_phase_sched #(
    parameter int PRESCALE  = 4,
    parameter int EMG_PHASE = 0,
    parameter int MIN_TIME  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic [7:0] MASK,
    input  logic       EMG,
    input  logic [4:0] Y_IN,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic [2:0] PHASE,
    output logic       PHASE_CHG,
    output logic       EMG_ACT
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [2:0]      EMG_PH     = 3'(EMG_PHASE);
    localparam logic [4:0]      MIN_T      = 5'(MIN_TIME);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t        state;
    logic [2:0]    phase;
    logic [4:0]    timer;
    logic [PW-1:0] presc;
    logic          phase_chg;
    logic          emg_act;
    logic [2:0]    nxt_run;
    logic [2:0]    nxt_emg;

    // Nearest set mask bit above cur (wrapping); falls back to cur when nothing else is set.
    function automatic logic [2:0] next_enabled(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] cand;
        logic [2:0] result;
        result = cur;
        for (int i = 7; i >= 1; i--) begin
            cand = cur + 3'(i);
            if (mask[cand]) result = cand;
        end
        return result;
    endfunction

    always_comb begin
        nxt_run = next_enabled(phase, MASK);
        nxt_emg = next_enabled(EMG_PH, MASK);
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= 3'd0;
            timer     <= 5'd0;
            presc     <= '0;
            phase_chg <= 1'b0;
            emg_act   <= 1'b0;
        end else begin
            phase_chg <= 1'b0;
            if (state == HOLD) begin
                if (!EMG) begin
                    phase     <= nxt_emg;
                    phase_chg <= (nxt_emg != phase);
                    emg_act   <= 1'b0;
                    state     <= EN ? LOAD : IDLE;
                end
            end else if (EMG) begin
                // Pre-emption wins over EN and over a same-cycle expiry.
                state     <= HOLD;
                phase     <= EMG_PH;
                phase_chg <= (EMG_PH != phase);
                emg_act   <= 1'b1;
                timer     <= 5'd0;
                presc     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (EN) state <= LOAD;
                    end
                    LOAD: begin
                        if (EN) begin
                            timer <= (Y_IN == 5'd0) ? MIN_T : Y_IN;
                            presc <= '0;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (EN) begin
                            if (presc == PRESC_LAST) begin
                                presc <= '0;
                                timer <= timer - 5'd1;
                                if (timer == 5'd1) begin
                                    phase     <= nxt_run;
                                    phase_chg <= (nxt_run != phase);
                                    state     <= LOAD;
                                end
                            end else begin
                                presc <= presc + PW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign S1        = phase[0];
    assign S2        = phase[1];
    assign S3        = phase[2];
    assign PHASE     = phase;
    assign PHASE_CHG = phase_chg;
    assign EMG_ACT   = emg_act;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Self-checking bench for traffic_phase_sched: models the mux duration table and scores
// the phase sequence and dwell times from a queue of expected phase changes.
module tb_traffic_phase_sched;

    logic       clk;
    logic       rst;
    logic       EN;
    logic [7:0] MASK;
    logic       EMG;
    logic [4:0] Y_IN;
    logic       S1;
    logic       S2;
    logic       S3;
    logic [2:0] PHASE;
    logic       PHASE_CHG;
    logic       EMG_ACT;

    typedef struct {
        logic [2:0] phase;
        int         dwell;   // 0 = dwell not checked
    } exp_t;

    exp_t       sb[$];
    logic [4:0] dur_tab [8];
    int         total;
    int         bad;
    int         cyc;
    int         last_cyc;

    traffic_phase_sched #(.PRESCALE(4), .EMG_PHASE(0), .MIN_TIME(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .EN        (EN),
        .MASK      (MASK),
        .EMG       (EMG),
        .Y_IN      (Y_IN),
        .S1        (S1),
        .S2        (S2),
        .S3        (S3),
        .PHASE     (PHASE),
        .PHASE_CHG (PHASE_CHG),
        .EMG_ACT   (EMG_ACT)
    );

    // Mux model: returns the duration of the currently selected input.
    assign Y_IN = dur_tab[{S3, S2, S1}];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] ph, input int dw);
        exp_t e;
        e.phase = ph;
        e.dwell = dw;
        sb.push_back(e);
    endtask

    // Wait for each expected phase change and compare phase and dwell against the queue.
    task automatic expect_seq(input int n, input int budget);
        exp_t e;
        int   waited;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (PHASE_CHG !== 1'b1 && waited < budget);
            e = sb.pop_front();
            total++;
            if (PHASE_CHG !== 1'b1) begin
                bad++;
                $display("FAIL seq_timeout: no PHASE_CHG within %0d cycles, wanted phase %0d", budget, e.phase);
            end else begin
                if (PHASE !== e.phase) begin
                    bad++;
                    $display("FAIL seq_phase: got %0d want %0d", PHASE, e.phase);
                end
                if (e.dwell != 0) begin
                    total++;
                    if (cyc - last_cyc != e.dwell) begin
                        bad++;
                        $display("FAIL seq_dwell: phase %0d dwell got %0d want %0d", e.phase, cyc - last_cyc, e.dwell);
                    end
                end
                last_cyc = cyc;
            end
        end
    endtask

    // Run n cycles expecting a fixed phase and no PHASE_CHG pulses.
    task automatic watch_quiet(input int n, input logic [2:0] ph, input string name);
        int pulses;
        int wrong;
        pulses = 0;
        wrong  = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (PHASE_CHG !== 1'b0) pulses++;
            if (PHASE !== ph) wrong++;
        end
        total++;
        if (pulses != 0 || wrong != 0) begin
            bad++;
            $display("FAIL %s: pulses got %0d want 0, off-phase samples got %0d want 0 (phase %0d)", name, pulses, wrong, ph);
        end
    endtask

    task automatic check_outs(input logic [2:0] ph, input logic chg, input logic act, input string name);
        total++;
        if (PHASE !== ph || {S3, S2, S1} !== ph || PHASE_CHG !== chg || EMG_ACT !== act) begin
            bad++;
            $display("FAIL %s: phase/S/chg/act got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                     name, PHASE, {S3, S2, S1}, PHASE_CHG, EMG_ACT, ph, ph, chg, act);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        EN   = 1'b1;
        EMG  = 1'b1;
        MASK = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        check_outs(3'd0, 1'b0, 1'b0, "reset_outputs");
        rst = 1'b0;
        EN  = 1'b0;
        EMG = 1'b0;
        watch_quiet(5, 3'd0, "reset_idle_quiet");
        total++;
        if (EMG_ACT !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_emg_act: got %b want 0", EMG_ACT);
        end
    endtask

    task automatic test_rotation();
        MASK = 8'hFF;
        EN   = 1'b1;
        last_cyc = cyc + 1;
        for (int p = 0; p < 8; p++) push(3'(p + 1), 1 + 4 * (p + 1));
        expect_seq(8, 100);
    endtask

    task automatic test_skip_wrap();
        MASK = 8'b1000_0101;
        push(3'd2, 5);
        push(3'd7, 13);
        push(3'd0, 33);
        expect_seq(3, 100);
        MASK = 8'h00;
        watch_quiet(60, 3'd0, "mask_zero_reload");
    endtask

    task automatic test_zero_and_freeze();
        dur_tab[3] = 5'd0;
        MASK = 8'b0000_1001;
        push(3'd3, 0);
        push(3'd0, 5);
        expect_seq(2, 100);
        tick();
        tick();
        EN = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        EN = 1'b1;
        push(3'd3, 15);
        expect_seq(1, 100);
    endtask

    task automatic test_emergency();
        MASK = 8'hFF;
        push(3'd4, 5);
        push(3'd5, 21);
        expect_seq(2, 100);
        for (int i = 0; i < 24; i++) tick();
        EMG = 1'b1;
        tick();
        check_outs(3'd0, 1'b1, 1'b1, "emg_on_expiry");
        for (int i = 0; i < 3; i++) tick();
        check_outs(3'd0, 1'b0, 1'b1, "emg_hold");
        MASK = 8'b0001_0001;
        EMG  = 1'b0;
        tick();
        check_outs(3'd4, 1'b1, 1'b0, "emg_release");
        last_cyc = cyc;
        push(3'd0, 21);
        push(3'd4, 5);
        expect_seq(2, 100);
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        EMG = 1'b1;
        tick();
        check_outs(3'd0, 1'b0, 1'b0, "mid_reset");
    endtask

    task automatic test_emg_idle();
        rst = 1'b0;
        EN  = 1'b0;
        EMG = 1'b1;
        tick();
        check_outs(3'd0, 1'b0, 1'b1, "emg_idle_enter");
        EMG  = 1'b0;
        MASK = 8'b0000_0100;
        tick();
        check_outs(3'd2, 1'b1, 1'b0, "emg_idle_release");
        watch_quiet(20, 3'd2, "emg_idle_stays");
        MASK = 8'b0000_0101;
        EN   = 1'b1;
        last_cyc = cyc + 1;
        push(3'd0, 13);
        expect_seq(1, 100);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        last_cyc = 0;
        for (int i = 0; i < 8; i++) dur_tab[i] = 5'(i + 1);
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_zero_and_freeze();
        test_emergency();
        test_mid_reset();
        test_emg_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
